// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder
// Keyboard front end for the ATM user-input block. Receives PS/2
// device-to-host frames (scan code set 2) from the raw pins, tracks the
// break (F0) and extended (E0) prefixes, and turns each key press into a
// one-cycle ASCII strobe (digits, lowercase letters, Enter, Backspace).
//
// Ports
//   clk          system clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous, idle high)
//   ps2_data     raw PS/2 data pin (asynchronous, idle high)
//   ascii_code   last translated ASCII code, held until the next valid key
//   ascii_valid  one-cycle strobe, ascii_code updated in the same cycle
//   raw_code     last correctly framed byte, prefixes included
//   raw_valid    one-cycle strobe per correctly framed byte
//   frame_error  one-cycle strobe on parity, stop or timeout error
module ps2_ascii_decoder #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_code,
  output logic       ascii_valid,
  output logic [7:0] raw_code,
  output logic       raw_valid,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rxState_e;

  rxState_e         state_q, state_d;
  logic [1:0]       clkSync_q, dataSync_q;
  logic             clkPrev_q;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] idleCnt_q, idleCnt_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [7:0]       asciiCode_q, asciiCode_d;
  logic             asciiValid_q, asciiValid_d;
  logic [7:0]       rawCode_q, rawCode_d;
  logic             rawValid_q, rawValid_d;
  logic             frameError_q, frameError_d;

  logic             fall;
  logic             dataBit;
  logic [8:0]       xlat;

  // Set 2 make code to ASCII. Bit 8 flags a mapped code. Under the E0
  // prefix only keypad Enter is meaningful; everything else is dropped.
  function automatic logic [8:0] translate(input logic [7:0] code, input logic isExt);
    logic [8:0] r;
    r = 9'h000;
    if (isExt) begin
      if (code == 8'h5A) r = {1'b1, 8'h0D};
    end else begin
      case (code)
        8'h45: r = {1'b1, 8'h30};
        8'h16: r = {1'b1, 8'h31};
        8'h1E: r = {1'b1, 8'h32};
        8'h26: r = {1'b1, 8'h33};
        8'h25: r = {1'b1, 8'h34};
        8'h2E: r = {1'b1, 8'h35};
        8'h36: r = {1'b1, 8'h36};
        8'h3D: r = {1'b1, 8'h37};
        8'h3E: r = {1'b1, 8'h38};
        8'h46: r = {1'b1, 8'h39};
        8'h1C: r = {1'b1, 8'h61};
        8'h32: r = {1'b1, 8'h62};
        8'h21: r = {1'b1, 8'h63};
        8'h23: r = {1'b1, 8'h64};
        8'h24: r = {1'b1, 8'h65};
        8'h2B: r = {1'b1, 8'h66};
        8'h34: r = {1'b1, 8'h67};
        8'h33: r = {1'b1, 8'h68};
        8'h43: r = {1'b1, 8'h69};
        8'h3B: r = {1'b1, 8'h6A};
        8'h42: r = {1'b1, 8'h6B};
        8'h4B: r = {1'b1, 8'h6C};
        8'h3A: r = {1'b1, 8'h6D};
        8'h31: r = {1'b1, 8'h6E};
        8'h44: r = {1'b1, 8'h6F};
        8'h4D: r = {1'b1, 8'h70};
        8'h15: r = {1'b1, 8'h71};
        8'h2D: r = {1'b1, 8'h72};
        8'h1B: r = {1'b1, 8'h73};
        8'h2C: r = {1'b1, 8'h74};
        8'h3C: r = {1'b1, 8'h75};
        8'h2A: r = {1'b1, 8'h76};
        8'h1D: r = {1'b1, 8'h77};
        8'h22: r = {1'b1, 8'h78};
        8'h35: r = {1'b1, 8'h79};
        8'h1A: r = {1'b1, 8'h7A};
        8'h5A: r = {1'b1, 8'h0D};
        8'h66: r = {1'b1, 8'h08};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

  // The pins are asynchronous; the second sync stage and its delayed copy
  // give a clean one-cycle falling-edge pulse on ps2_clk.
  assign fall    = clkPrev_q & ~clkSync_q[1];
  assign dataBit = dataSync_q[1];
  assign xlat    = translate(shift_q, ext_q);

  // Receive FSM next state, idle timeout, prefix tracking and output
  // strobes. Strobes default low so each one lasts a single cycle.
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    idleCnt_d    = idleCnt_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    asciiCode_d  = asciiCode_q;
    asciiValid_d = 1'b0;
    rawCode_d    = rawCode_q;
    rawValid_d   = 1'b0;
    frameError_d = 1'b0;

    if (state_q == IDLE || fall) begin
      idleCnt_d = '0;
    end else begin
      idleCnt_d = idleCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fall && !dataBit) begin
          state_d  = DATA;
          bitCnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {dataBit, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = dataBit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dataBit && ((^shift_q) ^ parity_q)) begin
            rawCode_d  = shift_q;
            rawValid_d = 1'b1;
            if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else begin
              if (!brk_q && xlat[8]) begin
                asciiCode_d  = xlat[7:0];
                asciiValid_d = 1'b1;
              end
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            frameError_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon a stalled frame; the error lands TIMEOUT_CYCLES after the
    // last fall because it is raised on the edge the count reaches the
    // limit. Prefix flags are left alone.
    if (state_q != IDLE && !fall && (idleCnt_q + 1'b1) == TIMEOUT_LAST) begin
      state_d      = IDLE;
      idleCnt_d    = '0;
      frameError_d = 1'b1;
    end
  end

  // All state, including synchronizers, is registered here. Sync flops
  // reset to the idle-high level so no false fall appears after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync_q    <= 2'b11;
      dataSync_q   <= 2'b11;
      clkPrev_q    <= 1'b1;
      state_q      <= IDLE;
      bitCnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      idleCnt_q    <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      asciiCode_q  <= 8'h00;
      asciiValid_q <= 1'b0;
      rawCode_q    <= 8'h00;
      rawValid_q   <= 1'b0;
      frameError_q <= 1'b0;
    end else begin
      clkSync_q    <= {clkSync_q[0], ps2_clk};
      dataSync_q   <= {dataSync_q[0], ps2_data};
      clkPrev_q    <= clkSync_q[1];
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      idleCnt_q    <= idleCnt_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      asciiCode_q  <= asciiCode_d;
      asciiValid_q <= asciiValid_d;
      rawCode_q    <= rawCode_d;
      rawValid_q   <= rawValid_d;
      frameError_q <= frameError_d;
    end
  end

  assign ascii_code  = asciiCode_q;
  assign ascii_valid = asciiValid_q;
  assign raw_code    = rawCode_q;
  assign raw_valid   = rawValid_q;
  assign frame_error = frameError_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb_ps2_ascii_decoder
// Self-checking bench for ps2_ascii_decoder. Frames are bit-banged on the
// PS/2 pins; a keyboard model built from the code tables predicts which
// bytes, keys and errors should appear.
module tb_ps2_ascii_decoder;

  localparam int TIMEOUT = 40;
  localparam int HALF    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] asciiCode;
  logic       asciiValid;
  logic [7:0] rawCode;
  logic       rawValid;
  logic       frameError;

  int assertCount = 0;
  int failCount = 0;

  int gotRaw = 0, gotAscii = 0, gotErr = 0;
  int expRaw = 0, expAscii = 0, expErr = 0;
  logic [7:0] expAsciiCode = 8'h00;
  logic [7:0] expRawCode = 8'h00;
  bit mBrk = 1'b0, mExt = 1'b0;

  logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                   8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                   8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};

  ps2_ascii_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2Clk),
    .ps2_data(ps2Data),
    .ascii_code(asciiCode),
    .ascii_valid(asciiValid),
    .raw_code(rawCode),
    .raw_valid(rawValid),
    .frame_error(frameError)
  );

  always #5 clk = ~clk;

  // Count strobes and check the strobe invariants on every active cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rawValid) gotRaw++;
      if (asciiValid) gotAscii++;
      if (frameError) gotErr++;
      if (rawValid || asciiValid || frameError) begin
        assertCount++;
        if ((rawValid && frameError) || (asciiValid && !rawValid)) begin
          failCount++;
          $display("[TB] FAIL strobe_invariant: raw=%0b ascii=%0b err=%0b", rawValid, asciiValid, frameError);
        end
      end
    end
  end

  // Keyboard model lookup: bit 8 set when the key produces ASCII.
  function automatic logic [8:0] modelLookup(input logic [7:0] b, input bit ext);
    if (ext) return (b == 8'h5A) ? 9'h10D : 9'h000;
    for (int i = 0; i < 10; i++) if (digitCodes[i] == b) return {1'b1, 8'(8'h30 + i)};
    for (int i = 0; i < 26; i++) if (letterCodes[i] == b) return {1'b1, 8'(8'h61 + i)};
    if (b == 8'h5A) return 9'h10D;
    if (b == 8'h66) return 9'h108;
    return 9'h000;
  endfunction

  task automatic modelFrame(input logic [7:0] b, input bit good);
    logic [8:0] m;
    if (!good) begin
      expErr++;
    end else begin
      expRaw++;
      expRawCode = b;
      if (b == 8'hF0) mBrk = 1'b1;
      else if (b == 8'hE0) mExt = 1'b1;
      else begin
        m = modelLookup(b, mExt);
        if (!mBrk && m[8]) begin
          expAscii++;
          expAsciiCode = m[7:0];
        end
        mBrk = 1'b0;
        mExt = 1'b0;
      end
    end
  endtask

  task automatic modelReset();
    mBrk = 1'b0;
    mExt = 1'b0;
    expAsciiCode = 8'h00;
    expRawCode = 8'h00;
  endtask

  task automatic driveBit(input logic b);
    @(negedge clk) ps2Data = b;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit badParity, input bit badStop);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(badParity ? ^b : ~^b);
    driveBit(!badStop);
    ps2Data = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    assertCount++;
    if ({asciiCode, asciiValid, rawCode, rawValid, frameError} !== 19'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {asciiCode, asciiValid, rawCode, rawValid, frameError});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int rawHits, rawAt, asciiHits, asciiAt;
    b = 8'h15;
    rawHits = 0; rawAt = -1; asciiHits = 0; asciiAt = -1;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(~^b);
    @(negedge clk) ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    // Two sync stages plus the registered output: strobe on the third edge.
    for (int k = 1; k <= 2 * HALF; k++) begin
      @(negedge clk);
      if (rawValid) begin rawHits++; rawAt = k; end
      if (asciiValid) begin asciiHits++; asciiAt = k; end
      if (k == HALF) ps2Clk = 1'b1;
    end
    modelFrame(b, 1'b1);
    assertCount++;
    if (rawHits != 1 || rawAt != 3) begin
      failCount++;
      $display("[TB] FAIL basic_raw_strobe: got %0d pulses at %0d required 1 at 3", rawHits, rawAt);
    end
    assertCount++;
    if (asciiHits != 1 || asciiAt != 3) begin
      failCount++;
      $display("[TB] FAIL basic_ascii_strobe: got %0d pulses at %0d required 1 at 3", asciiHits, asciiAt);
    end
    assertCount++;
    if (rawCode !== 8'h15 || asciiCode !== 8'h71) begin
      failCount++;
      $display("[TB] FAIL basic_codes: got raw %h ascii %h required 15 71", rawCode, asciiCode);
    end
  endtask

  task automatic test_break();
    int raw0, ascii0;
    raw0 = gotRaw; ascii0 = gotAscii;
    applyStimulus(8'hF0, 0, 0); modelFrame(8'hF0, 1);
    applyStimulus(8'h15, 0, 0); modelFrame(8'h15, 1);
    assertCount++;
    if (gotRaw - raw0 != 2 || gotAscii != ascii0) begin
      failCount++;
      $display("[TB] FAIL break_release: got raw %0d ascii %0d required 2 0", gotRaw - raw0, gotAscii - ascii0);
    end
    applyStimulus(8'h16, 0, 0); modelFrame(8'h16, 1);
    repeat (50) @(negedge clk);
    assertCount++;
    if (asciiCode !== 8'h31 || gotAscii - ascii0 != 1) begin
      failCount++;
      $display("[TB] FAIL break_then_key: got %h (%0d strobes) required 31 (1)", asciiCode, gotAscii - ascii0);
    end
  endtask

  task automatic test_parity_error();
    int raw0, ascii0, err0;
    raw0 = gotRaw; ascii0 = gotAscii; err0 = gotErr;
    applyStimulus(8'h1C, 1, 0); modelFrame(8'h1C, 0);
    assertCount++;
    if (gotErr - err0 != 1 || gotRaw != raw0 || gotAscii != ascii0) begin
      failCount++;
      $display("[TB] FAIL parity_error: got err %0d raw %0d ascii %0d required 1 0 0", gotErr - err0, gotRaw - raw0, gotAscii - ascii0);
    end
    applyStimulus(8'h32, 0, 0); modelFrame(8'h32, 1);
    assertCount++;
    if (asciiCode !== 8'h62) begin
      failCount++;
      $display("[TB] FAIL parity_recover: got %h required 62", asciiCode);
    end
    err0 = gotErr; raw0 = gotRaw;
    applyStimulus(8'h24, 0, 1); modelFrame(8'h24, 0);
    assertCount++;
    if (gotErr - err0 != 1 || gotRaw != raw0 || asciiCode !== 8'h62) begin
      failCount++;
      $display("[TB] FAIL stop_error: got err %0d raw %0d ascii %h required 1 0 62", gotErr - err0, gotRaw - raw0, asciiCode);
    end
  endtask

  task automatic test_timeout();
    int hits, at, raw0;
    hits = 0; at = -1; raw0 = gotRaw;
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'($urandom_range(0, 1)));
    @(negedge clk) ps2Data = 1'($urandom_range(0, 1));
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    // Fall is seen two edges after the pin moves; error TIMEOUT later.
    for (int k = 1; k <= TIMEOUT + 10; k++) begin
      @(negedge clk);
      if (frameError) begin hits++; at = k; end
      if (k == HALF) ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    modelFrame(8'h00, 0);
    assertCount++;
    if (hits != 1 || at != TIMEOUT + 2) begin
      failCount++;
      $display("[TB] FAIL timeout_error: got %0d pulses at %0d required 1 at %0d", hits, at, TIMEOUT + 2);
    end
    assertCount++;
    if (gotRaw != raw0) begin
      failCount++;
      $display("[TB] FAIL timeout_no_raw: got %0d required 0", gotRaw - raw0);
    end
    applyStimulus(8'h5A, 0, 0); modelFrame(8'h5A, 1);
    assertCount++;
    if (asciiCode !== 8'h0D || rawCode !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL timeout_recover: got ascii %h raw %h required 0d 5a", asciiCode, rawCode);
    end
  endtask

  task automatic test_extended();
    int raw0, ascii0;
    applyStimulus(8'hE0, 0, 0); modelFrame(8'hE0, 1);
    applyStimulus(8'h5A, 0, 0); modelFrame(8'h5A, 1);
    assertCount++;
    if (asciiCode !== 8'h0D || gotAscii != expAscii) begin
      failCount++;
      $display("[TB] FAIL ext_enter: got %h (%0d strobes) required 0d (%0d)", asciiCode, gotAscii, expAscii);
    end
    applyStimulus(8'h45, 0, 0); modelFrame(8'h45, 1);
    raw0 = gotRaw; ascii0 = gotAscii;
    applyStimulus(8'hE0, 0, 0); modelFrame(8'hE0, 1);
    applyStimulus(8'h75, 0, 0); modelFrame(8'h75, 1);
    assertCount++;
    if (gotRaw - raw0 != 2 || gotAscii != ascii0 || asciiCode !== 8'h30) begin
      failCount++;
      $display("[TB] FAIL ext_unmapped: got raw %0d ascii %0d code %h required 2 0 30", gotRaw - raw0, gotAscii - ascii0, asciiCode);
    end
    applyStimulus(8'hE0, 0, 0); modelFrame(8'hE0, 1);
    applyStimulus(8'hF0, 0, 0); modelFrame(8'hF0, 1);
    applyStimulus(8'h5A, 0, 0); modelFrame(8'h5A, 1);
    applyStimulus(8'h05, 0, 0); modelFrame(8'h05, 1);
    assertCount++;
    if (gotRaw - raw0 != 6 || gotAscii != ascii0 || asciiCode !== 8'h30 || rawCode !== 8'h05) begin
      failCount++;
      $display("[TB] FAIL ext_break_unmapped: got raw %0d ascii %0d code %h rawcode %h required 6 0 30 05", gotRaw - raw0, gotAscii - ascii0, asciiCode, rawCode);
    end
  endtask

  task automatic test_reset_midframe();
    int err0;
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    assertCount++;
    if ({asciiCode, asciiValid, rawCode, rawValid, frameError} !== 19'd0) begin
      failCount++;
      $display("[TB] FAIL midframe_reset_outputs: got %h required 0", {asciiCode, asciiValid, rawCode, rawValid, frameError});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
    err0 = gotErr;
    repeat (4) @(negedge clk);
    applyStimulus(8'h66, 0, 0); modelFrame(8'h66, 1);
    assertCount++;
    if (asciiCode !== 8'h08 || gotErr != err0) begin
      failCount++;
      $display("[TB] FAIL midframe_recover: got %h errs %0d required 08 0", asciiCode, gotErr - err0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad;
    int sel;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2) b = 8'hF0;
      else if (sel == 2) b = 8'hE0;
      else if (sel == 3) b = 8'($urandom_range(0, 255));
      else if (sel < 7) b = digitCodes[$urandom_range(0, 9)];
      else b = letterCodes[$urandom_range(0, 25)];
      bad = ($urandom_range(0, 9) == 0);
      applyStimulus(b, bad, 1'b0);
      modelFrame(b, !bad);
      assertCount++;
      if (asciiCode !== expAsciiCode || rawCode !== expRawCode) begin
        failCount++;
        $display("[TB] FAIL random_codes[%0d]: got ascii %h raw %h required %h %h", n, asciiCode, rawCode, expAsciiCode, expRawCode);
      end
    end
    assertCount++;
    if (gotRaw != expRaw || gotAscii != expAscii || gotErr != expErr) begin
      failCount++;
      $display("[TB] FAIL random_counts: got %0d/%0d/%0d required %0d/%0d/%0d", gotRaw, gotAscii, gotErr, expRaw, expAscii, expErr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_parity_error();
    test_timeout();
    test_extended();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
Front-end keyboard stage that sits directly upstream of the ATM user-input block and drives its ascii_code input. It receives PS/2 device-to-host frames (scan code set 2) on the raw ps2_clk/ps2_data pins and tracks make, break and extended prefixes. Each key press is translated to a one-cycle ASCII strobe: digits, lowercase letters, Enter and Backspace.

Parameters:
TIMEOUT_CYCLES, 200000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned (2 ms at 100 MHz)

Ports:
clk  input  1  system clock, the only clock, all logic on its rising edge
reset  input  1  synchronous active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idle high
ps2_data  input  1  raw PS/2 data pin, asynchronous, idle high
ascii_code  output  8  last translated ASCII code, held until the next valid key
ascii_valid  output  1  one-cycle strobe, ascii_code updated in the same cycle
raw_code  output  8  last correctly framed byte, including prefixes
raw_valid  output  1  one-cycle strobe per correctly framed byte
frame_error  output  1  one-cycle strobe on parity, stop or timeout error

Behaviour:
- Sync: ps2_clk and ps2_data each pass through a 2-flop synchronizer. The sync flops reset to 1.
- Edge detect: a registered copy of synchronized ps2_clk. fall = prev 1 and current 0. ps2_data is sampled only in the cycle fall is high.
- Receive FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on fall with data=0 (start bit), go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE (glitch, no error).
- DATA: on each fall, shift data in LSB first. After the 8th bit, go to PARITY.
- PARITY: on fall, capture the bit and go to STOP.
- STOP: on fall, frame is good when data=1 and (XOR of 8 data bits XOR parity bit) = 1 (odd parity).
  - Good frame: raw_code/raw_valid set the next cycle.
  - Bad frame: frame_error pulses the next cycle instead.
  - Either way, return to IDLE.
- Timeout: an idle counter counts in any non-IDLE state, clears on every fall and is held at 0 in IDLE. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, and leave the prefix flags unchanged.
- Prefix flags are updated only on good frames:
  - 0xF0 sets brk.
  - 0xE0 sets ext.
  - Any other byte is a key code: translate it only when brk=0, then clear both flags.
  - E0 F0 xx therefore produces no output.
- Translation table (set 2 code -> ASCII):
  - Digits: 45->30, 16->31, 1E->32, 26->33, 25->34, 2E->35, 36->36, 3D->37, 3E->38, 46->39.
  - Letters a-z: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 61..7A in order.
  - 5A->0D. 66->08.
  - With ext=1, only 5A (keypad Enter) maps, to 0D. All other extended codes are discarded.
  - Unmapped codes produce raw_valid only.
- Latency: ascii_valid is asserted in the same cycle as raw_valid, which is the cycle after the fall that samples the stop bit.
- Typematic repeats: each repeated make code emits a fresh ascii_valid.
- At most one of raw_valid / frame_error is high in any cycle. ascii_valid implies raw_valid.
- Reset (also mid-frame): FSM to IDLE, partial frame dropped, brk=ext=0.
  - Reset values: ascii_code=00, raw_code=00, ascii_valid=0, raw_valid=0, frame_error=0, idle counter=0.
- No host-to-device transmission: ps2_clk and ps2_data are input-only.

Test Plan:
- Frame 0x15 (start 0, bits 10101000, parity 0, stop 1) -> raw_code=15, ascii_code=71, raw_valid and ascii_valid each high exactly 1 cycle, one cycle after the stop-bit fall.
- Frames F0, 15 -> raw_valid twice, no ascii_valid. A following 0x16 -> ascii_code=31, ascii_code held afterwards.
- Frame 0x1C with parity forced to 1 -> frame_error 1 cycle, no raw_valid, no ascii_valid. The next good 0x32 -> 62.
- 5 falling edges then a ps2_clk stall -> frame_error exactly TIMEOUT_CYCLES after the last fall, FSM back in IDLE. A subsequent 0x5A -> 0D.
- E0 5A -> 0D. E0 75 -> raw_valid only. E0 F0 5A -> nothing. Unmapped 0x05 -> raw_valid, ascii_code unchanged.
- Assert reset after 4 bits of a frame, then send 0x66 -> all outputs 0 during reset, then ascii_code=08 with no frame_error.
